// File: rtl/result_display.sv
// ============================================================================
//  Module      : result_display
//  Description : Converts a signed 8-bit result to four 7-segment digits
//                (sign, hundreds, tens, units) via sequential double-dabble.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module result_display (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] Result,
    input  logic       ResultValid,
    output logic [6:0] sign,
    output logic [6:0] hun,
    output logic [6:0] ten,
    output logic [6:0] uni,
    output logic       Busy,
    output logic       Done
);

    localparam logic [6:0] C_SEG_BLANK = 7'b1111111;
    localparam logic [6:0] C_SEG_MINUS = 7'b0111111;
    localparam logic [6:0] C_SEG_ZERO  = 7'b1000000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [11:0] r_bcd;
    logic [7:0]  r_shift;
    logic [2:0]  r_count;
    logic        r_neg;
    logic        r_pend_valid;
    logic [7:0]  r_pend_data;
    logic [6:0]  r_sign;
    logic [6:0]  r_hun;
    logic [6:0]  r_ten;
    logic [6:0]  r_uni;
    logic        r_done;

    logic        w_start;
    logic [7:0]  w_src;
    logic [7:0]  w_mag;
    logic [11:0] w_adj;
    logic [19:0] w_shifted;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // A strobe seen in IDLE wins over an older pending value.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_src        = Result;
        case (r_state)
            IDLE: begin
                if (ResultValid) begin
                    w_start      = 1'b1;
                    w_src        = Result;
                    w_state_next = CONV;
                end else if (r_pend_valid) begin
                    w_start      = 1'b1;
                    w_src        = r_pend_data;
                    w_state_next = CONV;
                end
            end
            CONV: begin
                if (r_count == 3'd7) begin
                    w_state_next = LOAD;
                end
            end
            LOAD: begin
                if (r_pend_valid) begin
                    w_start      = 1'b1;
                    w_src        = r_pend_data;
                    w_state_next = CONV;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_mag = w_src[7] ? (8'd0 - w_src) : w_src;

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < 3; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5) begin
                w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    assign w_shifted = {w_adj, r_shift} << 1;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state      <= IDLE;
            r_bcd        <= '0;
            r_shift      <= '0;
            r_count      <= '0;
            r_neg        <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_data  <= '0;
            r_sign       <= C_SEG_BLANK;
            r_hun        <= C_SEG_BLANK;
            r_ten        <= C_SEG_BLANK;
            r_uni        <= C_SEG_ZERO;
            r_done       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= 1'b0;

            if (w_start) begin
                r_shift      <= w_mag;
                r_neg        <= w_src[7];
                r_bcd        <= '0;
                r_count      <= '0;
                r_pend_valid <= 1'b0;
            end else if (r_state == CONV) begin
                r_bcd   <= w_shifted[19:8];
                r_shift <= w_shifted[7:0];
                r_count <= r_count + 3'd1;
            end

            // Capture after the consume so a strobe in LOAD refills pending.
            if (ResultValid && (r_state != IDLE)) begin
                r_pend_valid <= 1'b1;
                r_pend_data  <= Result;
            end

            if (r_state == LOAD) begin
                r_sign <= (r_neg && (r_bcd != 12'd0)) ? C_SEG_MINUS : C_SEG_BLANK;
                r_hun  <= (r_bcd[11:8] == 4'd0) ? C_SEG_BLANK : seg7(r_bcd[11:8]);
                r_ten  <= (r_bcd[11:4] == 8'd0) ? C_SEG_BLANK : seg7(r_bcd[7:4]);
                r_uni  <= seg7(r_bcd[3:0]);
                r_done <= 1'b1;
            end
        end
    end

    assign sign = r_sign;
    assign hun  = r_hun;
    assign ten  = r_ten;
    assign uni  = r_uni;
    assign Busy = (r_state != IDLE) || r_pend_valid;
    assign Done = r_done;

endmodule

`default_nettype wire

// File: doc/result_display.md
RESULT_DISPLAY -- requirements
Module: result_display

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Clock  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  synchronous active-high reset, sampled on Clock rising edge.
REQ-004 Result  input  8  butterfly output, signed two's complement (-128..127).
REQ-005 ResultValid  input  1  single-cycle strobe; Result is valid in the same cycle.
REQ-006 sign  output  7  sign digit segments, active-low, order gfedcba.
REQ-007 hun  output  7  hundreds digit segments, active-low, order gfedcba.
REQ-008 ten  output  7  tens digit segments, active-low, order gfedcba.
REQ-009 uni  output  7  units digit segments, active-low, order gfedcba.
REQ-010 Busy  output  1  high while a conversion is in progress or a value is pending.
REQ-011 Done  output  1  one-cycle pulse; all four displays updated on this edge.

Function
REQ-012 The FSM SHALL have three states: IDLE, CONV and LOAD.
REQ-013 Magnitude SHALL be |Result| as an 8-bit unsigned value; -128 gives 128; the sign flag is Result[7].
REQ-014 Conversion SHALL use sequential double-dabble: 12-bit BCD (three digits) plus 8-bit shift register.
REQ-015 Per CONV cycle, each BCD digit >= 5 SHALL have 3 added before the single left shift; exactly 8 CONV cycles.
REQ-016 Timing SHALL be, with the ResultValid-sampling edge in IDLE as edge 0:
  - edge 0: capture Result, go to CONV;
  - edges 1..8: shifts;
  - edge 8: CONV -> LOAD;
  - edge 9: display registers and Done updated.
REQ-017 Done SHALL be high exactly the one cycle after edge 9; total latency is 9 edges.
REQ-018 Segment codes SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; blank=1111111.
REQ-019 sign SHALL be 0111111 (minus) for negative values, else blank; zero displays no minus.
REQ-020 Leading zeros SHALL be blanked: hun blank if 0; ten blank if hun and ten are both 0; uni is always shown.
REQ-021 A one-entry pending register SHALL capture ResultValid sampled in CONV or LOAD; a later strobe overwrites it (latest wins).
REQ-022 In LOAD, pending empty SHALL give LOAD -> IDLE.
REQ-023 In LOAD, pending valid SHALL give LOAD -> CONV, loading the pending value; that edge is edge 0 of the new conversion.
REQ-024 ResultValid in LOAD while pending is consumed SHALL refill pending with the new Result.
REQ-025 Busy SHALL be high in CONV and LOAD, and whenever pending is valid.
REQ-026 Display outputs SHALL change only on a Done edge, never mid-conversion.

Reset
REQ-027 Reset SHALL give: sign=1111111, hun=1111111, ten=1111111, uni=1000000 (shows "0"), Busy=0, Done=0, state IDLE, pending cleared.
REQ-028 Reset SHALL take priority over ResultValid and all state transitions, including mid-conversion.

Verification
REQ-029 Reset asserted 2 cycles -> sign/hun/ten blank, uni=1000000, Busy=0, Done=0.
REQ-030 Result=8'h7B strobe -> at edge 9: sign blank, hun=1111001, ten=0100100, uni=0110000; Done one cycle.
REQ-031 Result=8'h80 -> sign=0111111, hun=1111001, ten=0100100, uni=0000000.
REQ-032 Result=8'hF9 -> sign=0111111, hun and ten blank, uni=1111000.
REQ-033 Result=8'h0A -> hun blank, ten=1111001, uni=1000000.
REQ-034 Strobes of 5 (edge 0), 10 (edge 3), 20 (edge 5):
  - edge 9: shows 5;
  - edge 18: shows 20 (ten=0100100, uni=1000000);
  - 10 is never shown; exactly two Done pulses; Busy stays high edges 0..18.
REQ-035 Reset at edge 4 of a conversion with pending valid -> REQ-027 values; no Done afterwards.
